// File: rtl/alu_issue.sv
// ALU issue stage: operand forwarding, load-use stall and ALU control decode.
// Registered valid/ready handoff into the EX stage.
module alu_issue #(
    parameter int XLen = 32,
    parameter int NOps = 5,
    localparam int NOpsWidth = $clog2(NOps)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    input  logic [4:0]           rd_addr_i,
    input  logic [XLen-1:0]      rs1_data_i,
    input  logic [XLen-1:0]      rs2_data_i,
    input  logic [XLen-1:0]      imm_i,
    input  logic                 alu_src_i,
    input  logic [1:0]           alu_op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b5_i,
    input  logic                 op5_i,
    input  logic                 mem_valid_i,
    input  logic                 mem_load_i,
    input  logic [4:0]           mem_rd_i,
    input  logic [XLen-1:0]      mem_data_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_rd_i,
    input  logic [XLen-1:0]      wb_data_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLen-1:0]      a_o,
    output logic [XLen-1:0]      b_o,
    output logic [NOpsWidth-1:0] alu_control_o,
    output logic [4:0]           rd_addr_o
);

    logic                 hazard;
    logic                 accept;
    logic                 mem_rs1, mem_rs2;
    logic                 wb_rs1, wb_rs2;
    logic [XLen-1:0]      fwd_a, fwd_b;
    logic [2:0]           ctrl;

    assign mem_rs1 = mem_valid_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs1_addr_i);
    assign mem_rs2 = mem_valid_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs2_addr_i);
    assign wb_rs1  = wb_valid_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_addr_i);
    assign wb_rs2  = wb_valid_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_addr_i);

    // A load result is not yet available in MEM, so any consumer must wait.
    assign hazard = valid_i && mem_load_i && (mem_rs1 || (mem_rs2 && !alu_src_i));

    assign ready_o = (!valid_o || ready_i) && !hazard && !flush_i;
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        fwd_a = rs1_data_i;
        if (mem_rs1) begin
            fwd_a = mem_data_i;
        end else if (wb_rs1) begin
            fwd_a = wb_data_i;
        end
    end

    always_comb begin
        fwd_b = rs2_data_i;
        if (alu_src_i) begin
            fwd_b = imm_i;
        end else if (mem_rs2) begin
            fwd_b = mem_data_i;
        end else if (wb_rs2) begin
            fwd_b = wb_data_i;
        end
    end

    always_comb begin
        ctrl = 3'b000;
        unique case (alu_op_i)
            2'b00: ctrl = 3'b000;
            2'b01: ctrl = 3'b001;
            2'b10: begin
                unique case (funct3_i)
                    3'b000:  ctrl = (funct7b5_i && op5_i) ? 3'b001 : 3'b000;
                    3'b010:  ctrl = 3'b101;
                    3'b110:  ctrl = 3'b011;
                    3'b111:  ctrl = 3'b010;
                    default: ctrl = 3'b000;
                endcase
            end
            default: ctrl = 3'b000;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (accept) begin
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_o           <= '0;
            b_o           <= '0;
            alu_control_o <= '0;
            rd_addr_o     <= '0;
        end else if (accept) begin
            a_o           <= fwd_a;
            b_o           <= fwd_b;
            alu_control_o <= NOpsWidth'(ctrl);
            rd_addr_o     <= rd_addr_i;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic        alu_src_i;
    logic [1:0]  alu_op_i;
    logic [2:0]  funct3_i;
    logic        funct7b5_i, op5_i;
    logic        mem_valid_i, mem_load_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] a_o, b_o;
    logic [2:0]  alu_control_o;
    logic [4:0]  rd_addr_o;

    int total = 0;
    int bad   = 0;

    alu_issue dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .alu_src_i(alu_src_i),
        .alu_op_i(alu_op_i), .funct3_i(funct3_i),
        .funct7b5_i(funct7b5_i), .op5_i(op5_i),
        .mem_valid_i(mem_valid_i), .mem_load_i(mem_load_i),
        .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .a_o(a_o), .b_o(b_o),
        .alu_control_o(alu_control_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
        rs1_data_i = 0; rs2_data_i = 0; imm_i = 0; alu_src_i = 0;
        alu_op_i = 0; funct3_i = 0; funct7b5_i = 0; op5_i = 0;
        mem_valid_i = 0; mem_load_i = 0; mem_rd_i = 0; mem_data_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0;
        flush_i = 0; ready_i = 1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v"}, 32'(valid_o), 32'd0);
        chk({tag, "_a"}, a_o, 32'd0);
        chk({tag, "_b"}, b_o, 32'd0);
        chk({tag, "_c"}, 32'(alu_control_o), 32'd0);
        chk({tag, "_rd"}, 32'(rd_addr_o), 32'd0);
    endtask

    logic [1:0] sw_op  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b01, 2'b11, 2'b10};
    logic [2:0] sw_f3  [8] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100,
                               3'b111, 3'b110, 3'b000};
    logic       sw_f7  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1};
    logic       sw_o5  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0};
    logic [2:0] sw_exp [8] = '{3'b001, 3'b101, 3'b011, 3'b010, 3'b000,
                               3'b001, 3'b000, 3'b000};

    initial begin
        idle();
        rst_ni = 0;
        #3;
        chk_all_zero("rst");
        @(posedge clk_i);
        #1;
        rst_ni = 1;

        // add x3 = x1 + x2
        valid_i = 1; rs1_addr_i = 1; rs2_addr_i = 2; rd_addr_i = 3;
        rs1_data_i = 5; rs2_data_i = 7;
        #1;
        chk("add_rdy", 32'(ready_o), 32'd1);
        step();
        chk("add_v", 32'(valid_o), 32'd1);
        chk("add_a", a_o, 32'd5);
        chk("add_b", b_o, 32'd7);
        chk("add_c", 32'(alu_control_o), 32'd0);
        chk("add_rd", 32'(rd_addr_o), 32'd3);

        // forwarding priority
        rs1_addr_i = 4; rs2_addr_i = 4; rs1_data_i = 32'h11;
        rs2_data_i = 32'h22; rd_addr_i = 12;
        mem_valid_i = 1; mem_rd_i = 4; mem_data_i = 32'hAA;
        wb_valid_i = 1; wb_rd_i = 4; wb_data_i = 32'hBB;
        step();
        chk("fwd_mem_a", a_o, 32'hAA);
        chk("fwd_mem_b", b_o, 32'hAA);
        mem_valid_i = 0;
        step();
        chk("fwd_wb_a", a_o, 32'hBB);
        chk("fwd_wb_b", b_o, 32'hBB);
        mem_valid_i = 1; mem_rd_i = 0; wb_rd_i = 0; rs1_addr_i = 0;
        rs2_addr_i = 0;
        step();
        chk("fwd_x0_a", a_o, 32'h11);
        chk("fwd_x0_b", b_o, 32'h22);
        mem_valid_i = 0; wb_valid_i = 0;
        rs1_data_i = 32'hFFFF_FFFF; alu_src_i = 1; imm_i = 32'h8000_0001;
        step();
        chk("wide_a", a_o, 32'hFFFF_FFFF);
        chk("wide_b", b_o, 32'h8000_0001);
        alu_src_i = 0;

        // decode sweep, back-to-back
        for (int i = 0; i < 8; i++) begin
            alu_op_i = sw_op[i]; funct3_i = sw_f3[i];
            funct7b5_i = sw_f7[i]; op5_i = sw_o5[i];
            rd_addr_i = 5'(i + 1);
            step();
            chk($sformatf("dec%0d", i), 32'(alu_control_o), 32'(sw_exp[i]));
            chk($sformatf("dec%0d_v", i), 32'(valid_o), 32'd1);
            chk($sformatf("dec%0d_rd", i), 32'(rd_addr_o), 32'(i + 1));
        end
        alu_op_i = 0; funct3_i = 0; funct7b5_i = 0; op5_i = 0;

        // backpressure
        rs1_data_i = 32'h100; rd_addr_i = 9;
        step();
        chk("bp_a0", a_o, 32'h100);
        ready_i = 0; rs1_data_i = 32'h200; rd_addr_i = 10;
        #1;
        chk("bp_rdy", 32'(ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_v%0d", i), 32'(valid_o), 32'd1);
            chk($sformatf("bp_a%0d", i), a_o, 32'h100);
            chk($sformatf("bp_rd%0d", i), 32'(rd_addr_o), 32'd9);
            chk($sformatf("bp_r%0d", i), 32'(ready_o), 32'd0);
        end
        ready_i = 1;
        #1;
        chk("bp_rdy1", 32'(ready_o), 32'd1);
        step();
        chk("bp_next_a", a_o, 32'h200);
        chk("bp_next_rd", 32'(rd_addr_o), 32'd10);

        // load-use on rs2
        rs1_addr_i = 1; rs1_data_i = 1; rs2_addr_i = 6;
        rs2_data_i = 32'h60; rd_addr_i = 7;
        mem_valid_i = 1; mem_load_i = 1; mem_rd_i = 6;
        mem_data_i = 32'h66;
        #1;
        chk("lu_rdy", 32'(ready_o), 32'd0);
        step();
        chk("lu_bubble", 32'(valid_o), 32'd0);
        chk("lu_rdy2", 32'(ready_o), 32'd0);
        mem_load_i = 0;
        #1;
        chk("lu_clr_rdy", 32'(ready_o), 32'd1);
        step();
        chk("lu_clr_v", 32'(valid_o), 32'd1);
        chk("lu_clr_b", b_o, 32'h66);
        chk("lu_clr_rd", 32'(rd_addr_o), 32'd7);
        mem_load_i = 1; alu_src_i = 1; imm_i = 32'h77;
        #1;
        chk("lu_imm_rdy", 32'(ready_o), 32'd1);
        step();
        chk("lu_imm_v", 32'(valid_o), 32'd1);
        chk("lu_imm_b", b_o, 32'h77);
        chk("lu_imm_a", a_o, 32'd1);

        // flush dominates
        idle();
        flush_i = 1; valid_i = 1; ready_i = 0;
        rs1_data_i = 32'h999; rd_addr_i = 20;
        #1;
        chk("fl_rdy", 32'(ready_o), 32'd0);
        step();
        chk("fl_v", 32'(valid_o), 32'd0);
        chk("fl_a", a_o, 32'd1);
        flush_i = 0;

        // reset mid-stream
        idle();
        valid_i = 1; rs1_data_i = 32'h1234; rd_addr_i = 5;
        step();
        chk("pre_rst_a", a_o, 32'h1234);
        rst_ni = 0;
        #1;
        chk_all_zero("mid_rst");
        step();
        rst_ni = 1; rs1_data_i = 32'h55; rd_addr_i = 8;
        step();
        chk("post_rst_v", 32'(valid_o), 32'd1);
        chk("post_rst_a", a_o, 32'h55);
        chk("post_rst_rd", 32'(rd_addr_o), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter XLen, default 32, datapath width in bits.
REQ-002 Parameter NOps, default 5, number of ALU operations; NOpsWidth = $clog2(NOps), i.e. 3 by default.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  upstream (decode) holds a valid instruction.
REQ-006 ready_o  output  1  block accepts the upstream instruction this cycle.
REQ-007 rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  source and destination register indices.
REQ-008 rs1_data_i, rs2_data_i, imm_i  input  XLen each  register-file read data and sign-extended immediate.
REQ-009 alu_src_i  input  1  1 = operand B is imm_i, 0 = operand B is forwarded rs2.
REQ-010 alu_op_i  input  2  main-decoder ALU class; funct3_i  input  3; funct7b5_i  input  1; op5_i  input  1 (opcode bit 5).
REQ-011 mem_valid_i, mem_load_i  input  1 each; mem_rd_i  input  5; mem_data_i  input  XLen  MEM-stage forwarding source.
REQ-012 wb_valid_i  input  1; wb_rd_i  input  5; wb_data_i  input  XLen  WB-stage forwarding source.
REQ-013 flush_i  input  1  discard held and incoming instruction (branch taken).
REQ-014 valid_o  output  1; ready_i  input  1  handshake to the ALU/EX stage.
REQ-015 a_o, b_o  output  XLen each; alu_control_o  output  NOpsWidth; rd_addr_o  output  5  registered ALU operands, operation code and destination.

Function
REQ-016 accept = valid_i && ready_o && !flush_i; output payload registers load only on accept.
REQ-017 ready_o = (!valid_o || ready_i) && !hazard && !flush_i, purely combinational.
REQ-018 hazard = valid_i && mem_valid_i && mem_load_i && mem_rd_i != 0 && (mem_rd_i == rs1_addr_i || (mem_rd_i == rs2_addr_i && !alu_src_i)).
REQ-019 valid_o next = 0 if flush_i; else 1 on accept; else 0 if ready_i; else hold.
REQ-020 While valid_o && !ready_i, a_o, b_o, alu_control_o and rd_addr_o are held stable.
REQ-021 Latency: one cycle from accept to valid_o = 1 with the captured payload; full throughput of one instruction per cycle when ready_i stays high.
REQ-022 Forward A: if mem_valid_i && mem_rd_i != 0 && mem_rd_i == rs1_addr_i, use mem_data_i; else if wb_valid_i && wb_rd_i != 0 && wb_rd_i == rs1_addr_i, use wb_data_i; else use rs1_data_i.
REQ-023 Forward for rs2 uses identical rules; b_o captures imm_i when alu_src_i = 1, otherwise the forwarded rs2 value.
REQ-024 MEM match has priority over WB match; register 0 is never forwarded.
REQ-025 Decode alu_op_i = 00 to 000 (add).
REQ-026 Decode alu_op_i = 01 to 001 (sub).
REQ-027 Decode alu_op_i = 10 by funct3_i: 000 gives 001 when funct7b5_i && op5_i, else 000; 010 gives 101 (slt); 110 gives 011 (or); 111 gives 010 (and); any other funct3 gives 000.
REQ-028 Decode alu_op_i = 11 to 000.
REQ-029 flush_i dominates: in the cycle it is asserted, no accept occurs and valid_o is 0 next cycle, regardless of ready_i or hazard.
REQ-030 A hazard inserts exactly one bubble per cycle it persists: valid_o drops if ready_i is high, and the instruction is accepted once mem_load_i or the match clears.
REQ-031 The data path performs no arithmetic; operands pass unchanged, at full XLen width, with no truncation.

Reset
REQ-032 While rst_ni = 0: valid_o = 0, a_o = 0, b_o = 0, alu_control_o = 000, rd_addr_o = 0, applied asynchronously.
REQ-033 Release of rst_ni is synchronous to clk_i; the first accept can occur on the first rising edge after release.
REQ-034 Reset mid-handshake discards the held instruction; no partial payload is retained.

Verification
REQ-035 Back-to-back flow: with ready_i = 1, issue add x3 = x1 + x2 (rs1 = 5, rs2 = 7) -> next cycle valid_o = 1, a_o = 5, b_o = 7, alu_control_o = 000, rd_addr_o = 3.
REQ-036 Forwarding priority: rs1 = x4, mem_rd_i = 4 with data 0xAA, wb_rd_i = 4 with data 0xBB -> a_o = 0xAA; then set mem_valid_i = 0 -> a_o = 0xBB; then set rs1 = x0 with both stages targeting x0 -> a_o = rs1_data_i.
REQ-037 Backpressure: ready_i = 0 for 3 cycles after a valid_o -> ready_o = 0, and the payload is unchanged for all 3 cycles; on ready_i = 1 the next instruction appears one cycle later.
REQ-038 Load-use: mem_load_i = 1 with mem_rd_i = 6 and rs2 = x6, alu_src_i = 0 -> ready_o = 0 for one cycle and a bubble (valid_o = 0); with alu_src_i = 1 -> no stall.
REQ-039 Decode sweep: alu_op_i = 10 with funct3_i in {000 with funct7b5_i = 1 and op5_i = 1, 010, 110, 111, 100} -> alu_control_o = {001, 101, 011, 010, 000}.
REQ-040 Flush and reset: flush_i with valid_i = 1 and ready_i = 0 -> valid_o = 0 next cycle and no accept; rst_ni low mid-stream -> all outputs 0 immediately.
